fp16_result_unloader: RTL and testbench

Output-side counterpart of the byte-wide fp16 operand loader.
- Captures 16-bit fp16 calculator results into a small FIFO.
- Returns each result over an 8-bit valid/ready byte stream, high byte first, then low byte.
- Optionally appends a third classification status byte.
- Sits between the fp16 calculator result and the external 8-bit host interface.

---
 rtl/fp16_pkg.sv | 21 ++
 rtl/fp16_result_unloader_if.sv | 12 +
 rtl/fp16_result_fifo.sv | 52 +++++
 rtl/fp16_result_unloader.sv | 156 +++++++++++++++
 tb/tb_fp16_result_unloader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, status byte bit positions and unloader FSM states.
package fp16_pkg;

  localparam int FP16_EXP_W   = 5;
  localparam int FP16_MANT_W  = 10;
  localparam int FP16_EXP_MAX = 31;

  localparam int STAT_ZERO_BIT = 0;
  localparam int STAT_SUBN_BIT = 1;
  localparam int STAT_INF_BIT  = 2;
  localparam int STAT_NAN_BIT  = 3;
  localparam int STAT_SIGN_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_HI   = 2'd1,
    ST_SEND_LO   = 2'd2,
    ST_SEND_STAT = 2'd3
  } unloader_state_e;

endpackage

// File: rtl/fp16_result_unloader_if.sv
// Outgoing 8-bit valid/ready byte stream toward the host.
interface fp16_result_unloader_if;

  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       last_byte;

  modport master (output data_out, output data_valid, output last_byte, input data_ready);
  modport slave  (input data_out, input data_valid, input last_byte, output data_ready);

endinterface

// File: rtl/fp16_result_fifo.sv
// Synchronous result FIFO; pointers carry one wrap bit to tell full from empty.
module fp16_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update for accepted pushes and pops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Entry storage, cleared on reset so aborted results never reappear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push && !full) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fp16_result_unloader.sv
// Queues fp16 results and streams each one out as high byte, low byte and
// an optional classification status byte.
module fp16_result_unloader
  import fp16_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter bit SEND_STATUS = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   result_in,
  input  logic                          capture,
  output logic                          capture_ready,
  fp16_result_unloader_if.master        byte_if,
  output logic                          busy,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  unloader_state_e        state_r, state_next_s;
  logic [15:0]            head_s, hold_r;
  logic                   full_s, empty_s, push_s, pop_s, handshake_s;
  logic [FP16_EXP_W-1:0]  exp_s;
  logic [FP16_MANT_W-1:0] mant_s;
  logic [7:0]             status_s, status_r;
  logic [7:0]             data_out_r, data_out_next_s;
  logic                   data_valid_r, data_valid_next_s;
  logic                   last_byte_r, last_byte_next_s;
  logic                   overflow_r;

  assign push_s        = capture && !full_s;
  assign handshake_s   = data_valid_r && byte_if.data_ready;
  assign capture_ready = !full_s;
  assign busy          = (state_r != ST_IDLE) || !empty_s;
  assign overflow      = overflow_r;

  assign byte_if.data_out   = data_out_r;
  assign byte_if.data_valid = data_valid_r;
  assign byte_if.last_byte  = last_byte_r;

  fp16_result_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (result_in),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Classify the FIFO head so its status byte is captured together with it.
  always_comb begin
    exp_s    = head_s[FP16_MANT_W +: FP16_EXP_W];
    mant_s   = head_s[FP16_MANT_W-1:0];
    status_s = 8'h00;
    status_s[STAT_ZERO_BIT] = (exp_s == {FP16_EXP_W{1'b0}}) && (mant_s == {FP16_MANT_W{1'b0}});
    status_s[STAT_SUBN_BIT] = (exp_s == {FP16_EXP_W{1'b0}}) && (mant_s != {FP16_MANT_W{1'b0}});
    status_s[STAT_INF_BIT]  = (exp_s == FP16_EXP_W'(FP16_EXP_MAX)) && (mant_s == {FP16_MANT_W{1'b0}});
    status_s[STAT_NAN_BIT]  = (exp_s == FP16_EXP_W'(FP16_EXP_MAX)) && (mant_s != {FP16_MANT_W{1'b0}});
    status_s[STAT_SIGN_BIT] = head_s[15];
  end

  // Next state and next registered stream outputs; the high byte comes
  // straight from the FIFO head so it is presented on the pop edge.
  always_comb begin
    state_next_s      = state_r;
    pop_s             = 1'b0;
    data_out_next_s   = data_out_r;
    data_valid_next_s = data_valid_r;
    last_byte_next_s  = last_byte_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s             = 1'b1;
          state_next_s      = ST_SEND_HI;
          data_out_next_s   = head_s[15:8];
          data_valid_next_s = 1'b1;
          last_byte_next_s  = 1'b0;
        end else begin
          data_valid_next_s = 1'b0;
          last_byte_next_s  = 1'b0;
        end
      end
      ST_SEND_HI: begin
        if (handshake_s) begin
          state_next_s     = ST_SEND_LO;
          data_out_next_s  = hold_r[7:0];
          last_byte_next_s = !SEND_STATUS;
        end else begin
          data_out_next_s  = hold_r[15:8];
        end
      end
      ST_SEND_LO: begin
        if (handshake_s && SEND_STATUS) begin
          state_next_s     = ST_SEND_STAT;
          data_out_next_s  = status_r;
          last_byte_next_s = 1'b1;
        end else if (handshake_s) begin
          state_next_s      = ST_IDLE;
          data_valid_next_s = 1'b0;
          last_byte_next_s  = 1'b0;
        end else begin
          data_out_next_s  = hold_r[7:0];
        end
      end
      ST_SEND_STAT: begin
        if (handshake_s) begin
          state_next_s      = ST_IDLE;
          data_valid_next_s = 1'b0;
          last_byte_next_s  = 1'b0;
        end else begin
          data_out_next_s  = status_r;
        end
      end
      default: begin
        state_next_s      = ST_IDLE;
        data_valid_next_s = 1'b0;
        last_byte_next_s  = 1'b0;
      end
    endcase
  end

  // FSM state, holding registers and registered stream outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_r       <= 16'h0000;
      status_r     <= 8'h00;
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      last_byte_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      data_out_r   <= data_out_next_s;
      data_valid_r <= data_valid_next_s;
      last_byte_r  <= last_byte_next_s;
      if (pop_s) begin
        hold_r   <= head_s;
        status_r <= status_s;
      end
    end
  end

  // Sticky overflow; a dropped capture outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (capture && full_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp16_result_unloader.sv
// Drives a status-byte and a two-byte unloader with shared stimulus and
// checks both against a queue-level model every cycle.
module tb_fp16_result_unloader;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] result_in;
  logic        capture, data_ready, clear_ovf;
  logic        cr0, cr1, busy0, busy1, ovf0, ovf1;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  fp16_result_unloader_if if0();
  fp16_result_unloader_if if1();
  assign if0.data_ready = data_ready;
  assign if1.data_ready = data_ready;

  fp16_result_unloader #(.DEPTH(DEPTH), .SEND_STATUS(1'b1)) u_dut_stat (
    .clk(clk), .reset(reset), .result_in(result_in), .capture(capture),
    .capture_ready(cr0), .byte_if(if0), .busy(busy0), .overflow(ovf0), .clear_ovf(clear_ovf)
  );

  fp16_result_unloader #(.DEPTH(DEPTH), .SEND_STATUS(1'b0)) u_dut_nostat (
    .clk(clk), .reset(reset), .result_in(result_in), .capture(capture),
    .capture_ready(cr1), .byte_if(if1), .busy(busy1), .overflow(ovf1), .clear_ovf(clear_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: pending results per unit, bytes of the result in flight, sticky flag.
  logic [15:0] mq [2][DEPTH];
  int          mq_n [2];
  logic [7:0]  mc [2][3];
  int          mc_n [2];
  logic        m_ovf [2];

  // Handshaken bytes as seen by the host.
  logic [7:0] log0[$], log1[$];
  logic       lst0[$], lst1[$];
  int         cyc0[$], cyc1[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_status(input logic [15:0] r);
    int v, e, m, st;
    v  = int'(r);
    e  = (v / 1024) % 32;
    m  = v % 1024;
    st = (v / 32768) * 16;
    if (e == 0 && m == 0)  st = st + 1;
    if (e == 0 && m != 0)  st = st + 2;
    if (e == 31 && m == 0) st = st + 4;
    if (e == 31 && m != 0) st = st + 8;
    return 8'(st);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq_n[k] = 0; mc_n[k] = 0; m_ovf[k] = 1'b0;
    end
  endtask

  task automatic clear_logs();
    log0.delete(); log1.delete(); lst0.delete(); lst1.delete(); cyc0.delete(); cyc1.delete();
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the model.
  task automatic step(input logic cap, input logic [15:0] res, input logic rdy, input logic clr);
    logic v, l, c, b, o, full;
    logic [7:0] d;
    logic [15:0] r;
    capture = cap; result_in = res; data_ready = rdy; clear_ovf = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? if0.data_valid : if1.data_valid;
      d = (k == 0) ? if0.data_out   : if1.data_out;
      l = (k == 0) ? if0.last_byte  : if1.last_byte;
      c = (k == 0) ? cr0 : cr1;
      b = (k == 0) ? busy0 : busy1;
      o = (k == 0) ? ovf0 : ovf1;
      check_eq($sformatf("dut%0d data_valid", k), 16'(v), 16'(mc_n[k] > 0));
      if (mc_n[k] > 0) check_eq($sformatf("dut%0d data_out", k), 16'(d), 16'(mc[k][0]));
      check_eq($sformatf("dut%0d last_byte", k), 16'(l), 16'(mc_n[k] == 1));
      check_eq($sformatf("dut%0d capture_ready", k), 16'(c), 16'(mq_n[k] < DEPTH));
      check_eq($sformatf("dut%0d busy", k), 16'(b), 16'(mc_n[k] > 0 || mq_n[k] > 0));
      check_eq($sformatf("dut%0d overflow", k), 16'(o), 16'(m_ovf[k]));
      if (v && rdy && k == 0) begin log0.push_back(d); lst0.push_back(l); cyc0.push_back(cyc); end
      if (v && rdy && k == 1) begin log1.push_back(d); lst1.push_back(l); cyc1.push_back(cyc); end

      full = (mq_n[k] == DEPTH);
      if (mc_n[k] > 0 && rdy) begin
        for (int i = 0; i < 2; i++) mc[k][i] = mc[k][i+1];
        mc_n[k]--;
      end else if (mc_n[k] == 0 && mq_n[k] > 0) begin
        r = mq[k][0];
        mc[k][0] = r[15:8]; mc[k][1] = r[7:0]; mc[k][2] = ref_status(r);
        mc_n[k] = (k == 0) ? 3 : 2;
        for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
        mq_n[k]--;
      end
      if (cap && !full) begin
        mq[k][mq_n[k]] = res;
        mq_n[k]++;
      end
      if (cap && full) m_ovf[k] = 1'b1;
      else if (clr)    m_ovf[k] = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  logic [7:0]  exp_t2 [4] = '{8'h08, 8'h11, 8'h04, 8'h02};
  logic [15:0] val_t2 [4] = '{16'h7E00, 16'h8000, 16'h7C00, 16'h0001};
  logic [7:0]  exp_t4 [9] = '{8'h11, 8'h11, 8'h00, 8'h22, 8'h22, 8'h00, 8'h33, 8'h33, 8'h00};
  logic [7:0]  exp_t5 [4] = '{8'hAB, 8'hCD, 8'h12, 8'h34};

  initial begin
    int cap_cyc, sel;
    logic [15:0] v;
    reset = 1'b1; capture = 1'b0; result_in = 16'h0000; data_ready = 1'b0; clear_ovf = 1'b0;
    model_reset();
    #3;
    check_eq("reset data_out", 16'(if0.data_out), 16'h0000);
    check_eq("reset data_valid", 16'(if0.data_valid), 16'h0000);
    check_eq("reset last_byte", 16'(if0.last_byte), 16'h0000);
    check_eq("reset busy", 16'(busy0), 16'h0000);
    check_eq("reset overflow", 16'(ovf0), 16'h0000);
    check_eq("reset capture_ready", 16'(cr0), 16'h0001);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Normal number with status byte and first-byte latency.
    clear_logs();
    cap_cyc = cyc;
    step(1'b1, 16'h3C00, 1'b1, 1'b0);
    repeat (6) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t1 byte count", 16'(log0.size()), 16'd3);
    if (log0.size() == 3) begin
      check_eq("t1 byte0", 16'(log0[0]), 16'h003C);
      check_eq("t1 byte1", 16'(log0[1]), 16'h0000);
      check_eq("t1 byte2", 16'(log0[2]), 16'h0000);
      check_eq("t1 last pattern", 16'({lst0[0], lst0[1], lst0[2]}), 16'h0001);
      check_eq("t1 latency", 16'(cyc0[0] - cap_cyc), 16'd2);
    end

    // Special-value classification.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, val_t2[i], 1'b1, 1'b0);
      repeat (6) step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_eq("t2 byte count", 16'(log0.size()), 16'd12);
    if (log0.size() == 12)
      for (int i = 0; i < 4; i++) check_eq($sformatf("t2 status %0d", i), 16'(log0[3*i+2]), 16'(exp_t2[i]));

    // Backpressure holds the high byte stable.
    clear_logs();
    step(1'b1, 16'hC500, 1'b0, 1'b0);
    repeat (7) step(1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("t3 held byte", 16'(if0.data_out), 16'h00C5);
    repeat (5) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t3 byte count", 16'(log0.size()), 16'd3);
    if (log0.size() == 3)
      check_eq("t3 bytes", {log0[0], log0[1]}, 16'hC500);
    if (log0.size() == 3)
      check_eq("t3 status", 16'(log0[2]), 16'h0010);

    // Overflow with a full FIFO and a result in flight.
    clear_logs();
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    check_eq("t4 capture_ready on D", 16'(cr0), 16'h0000);
    step(1'b1, 16'h4444, 1'b0, 1'b0);
    check_eq("t4 overflow set", 16'(ovf0), 16'h0001);
    repeat (14) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t4 byte count", 16'(log0.size()), 16'd9);
    if (log0.size() == 9)
      for (int i = 0; i < 9; i++) check_eq($sformatf("t4 byte %0d", i), 16'(log0[i]), 16'(exp_t4[i]));
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("t4 overflow cleared", 16'(ovf0), 16'h0000);

    // Two-byte unit, back-to-back results with one bubble.
    clear_logs();
    step(1'b1, 16'hABCD, 1'b1, 1'b0);
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t5 byte count", 16'(log1.size()), 16'd4);
    if (log1.size() == 4) begin
      for (int i = 0; i < 4; i++) check_eq($sformatf("t5 byte %0d", i), 16'(log1[i]), 16'(exp_t5[i]));
      check_eq("t5 last pattern", 16'({lst1[0], lst1[1], lst1[2], lst1[3]}), 16'h0005);
      check_eq("t5 bubble", 16'(cyc1[2] - cyc1[1]), 16'd2);
    end

    // Randomized traffic with biased special exponents.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 3);
      v = 16'($urandom);
      if (sel == 1) v = v & 16'h83FF;
      if (sel == 2) v = v | 16'h7C00;
      if (sel == 3) v = (v & 16'h8000) | (($urandom_range(0, 1) == 1) ? 16'h7C00 : 16'h0000);
      step(1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    repeat (12) step(1'b0, 16'h0000, 1'b1, 1'b1);

    // Reset during the low byte with two entries queued.
    step(1'b1, 16'h5A5A, 1'b0, 1'b0);
    step(1'b1, 16'h6B6B, 1'b0, 1'b0);
    step(1'b1, 16'h7C7C, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    data_ready = 1'b0;
    #1;
    check_eq("t6 low byte shown", 16'(if0.data_out), 16'h005A);
    #1 reset = 1'b1;
    #1;
    check_eq("t6 data_valid", 16'(if0.data_valid), 16'h0000);
    check_eq("t6 busy", 16'(busy0), 16'h0000);
    check_eq("t6 capture_ready", 16'(cr0), 16'h0001);
    model_reset();
    clear_logs();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t6 stale bytes", 16'(log0.size() + log1.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
